// File: rtl/timer_arbiter.sv
// Round-robin arbiter that lends one shared 4 s countdown timer to N_REQ requesters,
// sequencing its enable, returning per-owner done pulses and guarding against a stuck timer.
module timer_arbiter #(
  parameter int N_REQ       = 4,
  parameter int TIMEOUT_CYC = 500000000,
  parameter int COOL_CYC    = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  output logic             countEnable,
  input  logic             countFinish,
  input  logic             flash,
  output logic [N_REQ-1:0] grant,
  output logic [N_REQ-1:0] done,
  output logic [N_REQ-1:0] led,
  output logic             busy,
  output logic             timeoutErr,
  output logic [1:0]       state_dbg
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = (COOL_CYC > 1) ? $clog2(COOL_CYC + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_COOL = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [N_REQ-1:0] done_q, done_d;
  logic             ce_q, ce_d;
  logic             terr_q, terr_d;
  logic [PW-1:0]    rr_q, rr_d;
  logic [31:0]      wd_q, wd_d;
  logic [CW-1:0]    cool_q, cool_d;

  logic             sel_found;
  logic [PW-1:0]    sel_idx;

  // Search rr_q+1 .. rr_q (wrapping) so the last owner has the lowest priority.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = rr_q;
    for (int k = 1; k <= N_REQ; k++) begin
      int            idx;
      logic [PW-1:0] idx_p;
      idx = int'(rr_q) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      idx_p = PW'(idx);
      if (!sel_found && req[idx_p]) begin
        sel_found = 1'b1;
        sel_idx   = idx_p;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    done_d  = '0;
    ce_d    = ce_q;
    terr_d  = terr_q;
    rr_d    = rr_q;
    wd_d    = wd_q;
    cool_d  = cool_q;
    unique case (state_q)
      S_IDLE: begin
        if (sel_found) begin
          grant_d = N_REQ'(1) << sel_idx;
          ce_d    = 1'b1;
          rr_d    = sel_idx;
          wd_d    = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        wd_d = wd_q + 32'd1;
        // Finish beats abort beats timeout; only the owner's request matters here.
        if (countFinish) begin
          done_d  = grant_q;
          grant_d = '0;
          ce_d    = 1'b0;
          cool_d  = '0;
          state_d = S_COOL;
        end else if (!req[rr_q]) begin
          grant_d = '0;
          ce_d    = 1'b0;
          cool_d  = '0;
          state_d = S_COOL;
        end else if (wd_q == 32'(TIMEOUT_CYC - 1)) begin
          terr_d  = 1'b1;
          grant_d = '0;
          ce_d    = 1'b0;
          cool_d  = '0;
          state_d = S_COOL;
        end
      end
      S_COOL: begin
        ce_d = 1'b0;
        if (cool_q == CW'(COOL_CYC - 1)) state_d = S_IDLE;
        else cool_d = cool_q + CW'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      done_q  <= '0;
      ce_q    <= 1'b0;
      terr_q  <= 1'b0;
      rr_q    <= PW'(N_REQ - 1);
      wd_q    <= '0;
      cool_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      ce_q    <= ce_d;
      terr_q  <= terr_d;
      rr_q    <= rr_d;
      wd_q    <= wd_d;
      cool_q  <= cool_d;
    end
  end

  assign countEnable = ce_q;
  assign grant       = grant_q;
  assign done        = done_q;
  assign timeoutErr  = terr_q;
  assign busy        = (state_q != S_IDLE);
  assign state_dbg   = state_q;
  assign led         = grant_q & {N_REQ{flash}};

endmodule

// File: tb/tb_timer_arbiter.sv
// Directed bench for timer_arbiter: a shortened behavioural timer (10-cycle tick, finish
// after 40 enabled cycles), a table of grant transactions and hand-written corner sequences.
module tb_timer_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic       countEnable;
  logic       countFinish;
  logic       flash;
  logic [3:0] grant;
  logic [3:0] done;
  logic [3:0] led;
  logic       busy;
  logic       timeoutErr;
  logic [1:0] state_dbg;

  timer_arbiter #(.N_REQ(4), .TIMEOUT_CYC(50), .COOL_CYC(2)) dut (
    .clk(clk), .rst(rst), .req(req), .countEnable(countEnable),
    .countFinish(countFinish), .flash(flash), .grant(grant), .done(done),
    .led(led), .busy(busy), .timeoutErr(timeoutErr), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset / timer model ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] tm_cnt;
  logic [3:0] tick_cnt;
  logic       tm_flash;
  logic       fin_block, fin_force, flash_force;

  always @(posedge clk) begin
    if (rst || !countEnable) begin
      tm_cnt   <= 8'd0;
      tick_cnt <= 4'd0;
      tm_flash <= 1'b0;
    end else begin
      if (tm_cnt < 8'd40) tm_cnt <= tm_cnt + 8'd1;
      if (tick_cnt == 4'd9) begin
        tick_cnt <= 4'd0;
        tm_flash <= ~tm_flash;
      end else tick_cnt <= tick_cnt + 4'd1;
    end
  end

  assign countFinish = ((tm_cnt == 8'd40) && !fin_block) || fin_force;
  assign flash       = tm_flash | flash_force;

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic fail_bound(input string name);
    n_checks++;
    $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
  endtask

  task automatic cyc1();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = 4'b0000;
    repeat (2) cyc1();
    rst = 1'b0;
  endtask

  task automatic wait_grant(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      cyc1();
      if (grant != 4'b0000) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      cyc1();
      if (done != 4'b0000) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // ---------------- transaction table ----------------
  typedef struct {
    logic [3:0] req;
    logic [3:0] exp_grant;
    bit         abort;
    bit         chk_gap;
  } vec_t;

  vec_t tbl[10];

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin : main
    bit          ok;
    bit          saw_flash;
    int unsigned done_cyc;
    int unsigned g_cyc;

    tbl[0] = '{4'b1111, 4'b0001, 1'b0, 1'b0};
    tbl[1] = '{4'b1111, 4'b0010, 1'b0, 1'b1};
    tbl[2] = '{4'b1111, 4'b0100, 1'b0, 1'b1};
    tbl[3] = '{4'b1111, 4'b1000, 1'b0, 1'b1};
    tbl[4] = '{4'b1111, 4'b0001, 1'b0, 1'b1};
    tbl[5] = '{4'b1010, 4'b0010, 1'b0, 1'b0};
    tbl[6] = '{4'b1010, 4'b1000, 1'b0, 1'b1};
    tbl[7] = '{4'b0101, 4'b0001, 1'b0, 1'b0};
    tbl[8] = '{4'b0101, 4'b0100, 1'b1, 1'b0};
    tbl[9] = '{4'b0011, 4'b0001, 1'b0, 1'b0};

    fin_block   = 1'b0;
    fin_force   = 1'b0;
    flash_force = 1'b0;
    done_cyc    = 0;

    // Test 1: reset values, single request, done pulse, cool-down
    do_reset();
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_ce", 32'(countEnable), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_terr", 32'(timeoutErr), 32'h0);
    chk("rst_state", 32'(state_dbg), 32'h0);
    req = 4'b0001;
    cyc1();
    chk("t1_grant", 32'(grant), 32'h1);
    chk("t1_ce", 32'(countEnable), 32'h1);
    chk("t1_busy", 32'(busy), 32'h1);
    wait_done(100, ok);
    if (!ok) fail_bound("t1_done_wait");
    else begin
      chk("t1_done", 32'(done), 32'h1);
      chk("t1_grant_off", 32'(grant), 32'h0);
      chk("t1_ce_off0", 32'(countEnable), 32'h0);
      req = 4'b0000;
      cyc1();
      chk("t1_done_pulse", 32'(done), 32'h0);
      chk("t1_ce_off1", 32'(countEnable), 32'h0);
      chk("t1_busy_cool", 32'(busy), 32'h1);
      cyc1();
      chk("t1_busy_fall", 32'(busy), 32'h0);
    end

    // Test 2 and friends: table of round-robin transactions
    do_reset();
    foreach (tbl[i]) begin
      req = tbl[i].req;
      wait_grant(200, ok);
      if (!ok) begin
        fail_bound($sformatf("tbl%0d_grant_wait", i));
        continue;
      end
      g_cyc = cyc;
      chk($sformatf("tbl%0d_grant", i), 32'(grant), 32'(tbl[i].exp_grant));
      chk($sformatf("tbl%0d_ce", i), 32'(countEnable), 32'h1);
      if (tbl[i].chk_gap) chk($sformatf("tbl%0d_gap", i), g_cyc - done_cyc, 32'd3);
      if (tbl[i].abort) begin
        repeat (3) cyc1();
        req = tbl[i].req & ~tbl[i].exp_grant;
        cyc1();
        chk($sformatf("tbl%0d_abort_grant", i), 32'(grant), 32'h0);
        chk($sformatf("tbl%0d_abort_ce", i), 32'(countEnable), 32'h0);
        chk($sformatf("tbl%0d_abort_done", i), 32'(done), 32'h0);
      end else begin
        wait_done(100, ok);
        if (!ok) begin
          fail_bound($sformatf("tbl%0d_done_wait", i));
          continue;
        end
        done_cyc = cyc;
        chk($sformatf("tbl%0d_done", i), 32'(done), 32'(tbl[i].exp_grant));
        chk($sformatf("tbl%0d_done_grant", i), 32'(grant), 32'h0);
        cyc1();
        chk($sformatf("tbl%0d_done_pulse", i), 32'(done), 32'h0);
      end
    end
    req = 4'b0000;

    // Test 3: abort mid-RUN
    do_reset();
    req = 4'b0100;
    wait_grant(20, ok);
    if (!ok) fail_bound("t3_grant_wait");
    else begin
      chk("t3_grant", 32'(grant), 32'h4);
      repeat (10) cyc1();
      req = 4'b0000;
      cyc1();
      chk("t3_grant_off", 32'(grant), 32'h0);
      chk("t3_ce_off", 32'(countEnable), 32'h0);
      for (int i = 0; i < 6; i++) begin
        chk("t3_no_done", 32'(done), 32'h0);
        cyc1();
      end
      chk("t3_terr", 32'(timeoutErr), 32'h0);
    end

    // Test 5: finish and request drop together; stale finish while idle
    do_reset();
    req = 4'b0010;
    wait_grant(20, ok);
    if (!ok) fail_bound("t5_grant_wait");
    else begin
      chk("t5_grant", 32'(grant), 32'h2);
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
        if (countFinish) begin
          ok = 1'b1;
          break;
        end
        cyc1();
      end
      if (!ok) fail_bound("t5_finish_wait");
      else begin
        req = 4'b0000;
        cyc1();
        chk("t5_done", 32'(done), 32'h2);
        chk("t5_grant_off", 32'(grant), 32'h0);
      end
    end
    repeat (4) cyc1();
    chk("t5_idle", 32'(busy), 32'h0);
    fin_force = 1'b1;
    cyc1();
    fin_force = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("t5_idle_grant", 32'(grant), 32'h0);
      chk("t5_idle_done", 32'(done), 32'h0);
      cyc1();
    end

    // Test 4: watchdog abort with a timer that never finishes
    do_reset();
    fin_block = 1'b1;
    req = 4'b0001;
    wait_grant(20, ok);
    if (!ok) fail_bound("t4_grant_wait");
    else begin
      g_cyc = cyc;
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
        cyc1();
        if (done != 4'b0000) chk("t4_no_done", 32'(done), 32'h0);
        if (grant == 4'b0000) begin
          ok = 1'b1;
          break;
        end
      end
      if (!ok) fail_bound("t4_abort_wait");
      else begin
        chk("t4_run_len", cyc - g_cyc, 32'd50);
        chk("t4_terr", 32'(timeoutErr), 32'h1);
        chk("t4_ce", 32'(countEnable), 32'h0);
        req = 4'b0000;
        repeat (5) cyc1();
        chk("t4_terr_sticky", 32'(timeoutErr), 32'h1);
      end
    end
    fin_block = 1'b0;
    do_reset();
    chk("t4_terr_cleared", 32'(timeoutErr), 32'h0);

    // Test 6: reset mid-RUN, then led follows flash only while granted
    req = 4'b0001;
    wait_grant(20, ok);
    if (!ok) fail_bound("t6_grant_wait");
    else begin
      repeat (5) cyc1();
      rst = 1'b1;
      cyc1();
      chk("t6_rst_grant", 32'(grant), 32'h0);
      chk("t6_rst_ce", 32'(countEnable), 32'h0);
      chk("t6_rst_busy", 32'(busy), 32'h0);
      chk("t6_rst_done", 32'(done), 32'h0);
      rst = 1'b0;
    end
    req = 4'b1000;
    wait_grant(20, ok);
    if (!ok) fail_bound("t6_grant_wait2");
    else begin
      chk("t6_grant", 32'(grant), 32'h8);
      saw_flash = 1'b0;
      for (int i = 0; i < 30; i++) begin
        if (flash) saw_flash = 1'b1;
        chk("t6_led", 32'(led), flash ? 32'h8 : 32'h0);
        cyc1();
      end
      chk("t6_saw_flash", 32'(saw_flash), 32'h1);
      req = 4'b0000;
      cyc1();
      flash_force = 1'b1;
      #1;
      chk("t6_led_ungranted", 32'(led), 32'h0);
      flash_force = 1'b0;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
